// File: rtl/reg_serial_tx.sv
// reg_serial_tx: framed LSB-first serial transmitter (start, DATA_W data bits, stop) with valid/ready input.
// Optional even-parity bit before stop when REG_SERIAL_TX_PARITY_EN is defined.
module reg_serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
`ifdef REG_SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par, par_n;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t            state, state_n;
   logic [DATA_W-1:0] sreg, sreg_n;
   logic [BW-1:0]     bit_cnt, bit_n;
   logic [CW-1:0]     baud_cnt, baud_n;
   logic              done_n, tick;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sreg     <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         done     <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         sreg     <= sreg_n;
         bit_cnt  <= bit_n;
         baud_cnt <= baud_n;
         done     <= done_n;
`ifdef REG_SERIAL_TX_PARITY_EN
         par      <= par_n;
`endif
      end
   end
   assign tick = baud_cnt == CW'(CLKS_PER_BIT - 1);
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      bit_n   = bit_cnt;
      baud_n  = tick ? '0 : CW'(baud_cnt + 1'b1);
      done_n  = 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
      par_n   = par;
`endif
      if (clr) begin
         state_n = IDLE;
         sreg_n  = '0;
         bit_n   = '0;
         baud_n  = '0;
`ifdef REG_SERIAL_TX_PARITY_EN
         par_n   = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               baud_n = '0;
               if (din_valid) begin
                  state_n = START;
                  sreg_n  = din;
                  bit_n   = '0;
`ifdef REG_SERIAL_TX_PARITY_EN
                  par_n   = ^din;
`endif
               end
            end
            START: begin
               if (tick) begin
                  state_n = DATA;
                  bit_n   = '0;
               end
            end
            DATA: begin
               if (tick) begin
                  sreg_n = sreg >> 1;
                  bit_n  = BW'(bit_cnt + 1'b1);
`ifdef REG_SERIAL_TX_PARITY_EN
                  if (bit_cnt == BW'(DATA_W - 1)) state_n = PARITY;
`else
                  if (bit_cnt == BW'(DATA_W - 1)) state_n = STOP;
`endif
               end
            end
`ifdef REG_SERIAL_TX_PARITY_EN
            PARITY: begin
               if (tick) state_n = STOP;
            end
`endif
            STOP: begin
               if (tick) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
   always_comb begin
`ifdef REG_SERIAL_TX_PARITY_EN
      tx = state == START ? 1'b0 : state == DATA ? sreg[0] : state == PARITY ? par : 1'b1;
`else
      tx = state == START ? 1'b0 : state == DATA ? sreg[0] : 1'b1;
`endif
   end
   assign din_ready = state == IDLE;
   assign busy      = state != IDLE;
endmodule
